// File: rtl/arb_pkg.sv
// Shared types and helpers for the request scheduler / arbiter.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_e;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  // Widest requester vector the helpers below understand.
  localparam int ARB_MAX_REQ = 16;

  // One-hot (or zero) vector to binary index; zero input decodes to 0.
  function automatic logic [3:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    unique0 case (oh)
      16'h0001: idx = 4'd0;
      16'h0002: idx = 4'd1;
      16'h0004: idx = 4'd2;
      16'h0008: idx = 4'd3;
      16'h0010: idx = 4'd4;
      16'h0020: idx = 4'd5;
      16'h0040: idx = 4'd6;
      16'h0080: idx = 4'd7;
      16'h0100: idx = 4'd8;
      16'h0200: idx = 4'd9;
      16'h0400: idx = 4'd10;
      16'h0800: idx = 4'd11;
      16'h1000: idx = 4'd12;
      16'h2000: idx = 4'd13;
      16'h4000: idx = 4'd14;
      16'h8000: idx = 4'd15;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner picker: fixed priority (index 0 highest) or round-robin from rr_ptr.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: req/mode/rr_ptr in; win_oh (one-hot winner), win_id (its index), any (|req) out.
module arb_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDW-1:0]     win_id,
  output logic               any
);

  // Lowest set bit of v as a one-hot vector.
  function automatic logic [ARB_MAX_REQ-1:0] first_set(input logic [ARB_MAX_REQ-1:0] v);
    logic [ARB_MAX_REQ-1:0] r;
    r = '0;
    priority case (1'b1)
      v[0]:  r[0]  = 1'b1;
      v[1]:  r[1]  = 1'b1;
      v[2]:  r[2]  = 1'b1;
      v[3]:  r[3]  = 1'b1;
      v[4]:  r[4]  = 1'b1;
      v[5]:  r[5]  = 1'b1;
      v[6]:  r[6]  = 1'b1;
      v[7]:  r[7]  = 1'b1;
      v[8]:  r[8]  = 1'b1;
      v[9]:  r[9]  = 1'b1;
      v[10]: r[10] = 1'b1;
      v[11]: r[11] = 1'b1;
      v[12]: r[12] = 1'b1;
      v[13]: r[13] = 1'b1;
      v[14]: r[14] = 1'b1;
      v[15]: r[15] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                   rr_sel;
  logic [NUM_REQ-1:0]     rot;
  logic [ARB_MAX_REQ-1:0] scan_in;
  logic [ARB_MAX_REQ-1:0] scan_oh;
  logic [3:0]             scan_id;
  int                     j;
  int                     sum;

  always_comb begin
    rr_sel  = (arb_mode_e'(mode) == ARB_RR);
    rot     = '0;
    scan_in = '0;
    j       = 0;
    sum     = 0;
    win_oh  = '0;
    any     = |req;

    // Round-robin reuses the fixed scan: rotate so rr_ptr lands on bit 0,
    // scan for the lowest bit, then rotate the index back.
    for (int i = 0; i < NUM_REQ; i++) begin
      j = i + int'(rr_ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rot[i] = req[j];
    end

    scan_in[NUM_REQ-1:0] = rr_sel ? rot : req;
    scan_oh = first_set(scan_in);
    scan_id = onehot_to_idx(scan_oh);

    sum = int'(scan_id) + (rr_sel ? int'(rr_ptr) : 0);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    win_id = IDW'(sum);

    if (any) win_oh[win_id] = 1'b1;
  end

endmodule

// File: rtl/req_sched_arbiter.sv
// Single-owner arbiter for a shared mux/bus: fixed-priority or round-robin grant held until done.
// Latency: req -> gnt 1 cycle; minimum grant-to-grant period 3 cycles (GRANT, RELEASE, IDLE).
// Backpressure: requesters hold req until granted; owner holds the grant until done or dropping req.
// Ports: clk, rst_n (async, active-low); mode (0 fixed, 1 RR); req/done per requester;
//        gnt (registered one-hot), gnt_valid, gnt_id (datapath select), busy, timeout.
// Optional feature: define ARB_TIMEOUT_EN to bound ownership at MAX_HOLD cycles when others wait.
module req_sched_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDW-1:0]     gnt_id_nxt;
  logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDW-1:0]     win_id;
  logic               pick_any;
  logic               owner_end;
  logic               force_rel;

  arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .mode   (mode),
    .rr_ptr (rr_ptr),
    .win_oh (win_oh),
    .win_id (win_id),
    .any    (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  logic [HCW-1:0] hold_cnt;
  logic           timeout_q;

  // Forced release only when someone else is actually waiting.
  assign force_rel = (hold_cnt == HOLD_LAST) && |(req & ~gnt);
  assign timeout   = timeout_q;

  // Zero outside GRANT, so it starts from 0 on every new grant; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == ARB_GRANT) && force_rel && !owner_end;
      if (state != ARB_GRANT)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + HCW'(1);
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign force_rel       = 1'b0;
  assign timeout         = 1'b0;
`endif

  // A dropped req is treated exactly like done; other requesters' done is ignored.
  assign owner_end = done[gnt_id] | ~req[gnt_id];

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt  = ARB_GRANT;
          gnt_nxt    = win_oh;
          gnt_id_nxt = win_id;
        end
      end
      ARB_GRANT: begin
        if (owner_end || force_rel) begin
          state_nxt  = ARB_RELEASE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
          rr_ptr_nxt = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
      end
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign gnt_valid = |gnt;
  assign busy      = (state != ARB_IDLE);

  a_gnt_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt) && (!gnt_valid || gnt[gnt_id]));

endmodule
